// File: rtl/tinyqv_instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tinyqv_instr_fetch_pkg
//  Description : Shared fetch-stage definitions: FSM state encodings, the
//                RISC-V compressed-instruction test and the default reset PC.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package tinyqv_instr_fetch_pkg;

   // START  : just out of reset, restart not yet issued
   // RESTART: fetch_restart is high, memory is (re)starting the stream
   // RUN    : stream flowing, halfwords accepted into the buffer
   typedef enum logic [1:0] {
      ST_START   = 2'd0,
      ST_RESTART = 2'd1,
      ST_RUN     = 2'd2
   } fetch_state_e;

   localparam int unsigned DEFAULT_RESET_ADDR = 0;

   // Any encoding other than 2'b11 in the low bits is a 16-bit instruction.
   function automatic logic is_compressed(input logic [1:0] lo_bits);
      return (lo_bits != 2'b11);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tinyqv_instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : tinyqv_instr_fetch_if
//  Description : Bundles the memory-side halfword stream and the core-side
//                instruction/branch signals of the fetch stage.
//  Ports       : fetch_addr/fetch_restart/fetch_stall  -> memory controller
//                fetch_data/fetch_data_ready           <- memory controller
//                instr/pc/is_stall                     -> core/decoder
//                instr_complete/branch/branch_target   <- core
//                modport master = fetch unit, slave = surrounding system
//  Revision    : 1.0  initial release
// ============================================================================
interface tinyqv_instr_fetch_if #(
   parameter int ADDR_W = 24
);
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_restart;
   logic              fetch_stall;
   logic [15:0]       fetch_data;
   logic              fetch_data_ready;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] pc;
   logic              is_stall;
   logic              instr_complete;
   logic              branch;
   logic [ADDR_W-1:0] branch_target;

   modport master (
      output fetch_addr, fetch_restart, fetch_stall, instr, pc, is_stall,
      input  fetch_data, fetch_data_ready, instr_complete, branch, branch_target
   );

   modport slave (
      input  fetch_addr, fetch_restart, fetch_stall, instr, pc, is_stall,
      output fetch_data, fetch_data_ready, instr_complete, branch, branch_target
   );
endinterface
`default_nettype wire

// File: rtl/tinyqv_instr_fetch_hw_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tinyqv_hw_fifo
//  Description : DEPTH x 16-bit halfword FIFO. One push per cycle, pop of 0,
//                1 or 2 entries per cycle, synchronous flush. Exposes the two
//                head entries so a full 32-bit instruction can be read.
//  Ports       : clk, rstn        clock, async active-low reset
//                flush_i          empty the FIFO (wins over push/pop)
//                push_i, data_i   write data_i at tail
//                pop_n_i          number of entries to pop (0..2)
//                head0_o, head1_o entries at head and head+1
//                count_o          number of valid entries (0..DEPTH)
//  Revision    : 1.0  initial release
// ============================================================================
module tinyqv_hw_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [15:0]              data_i,
   input  logic [1:0]               pop_n_i,
   output logic [15:0]              head0_o,
   output logic [15:0]              head1_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [15:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_next;

   // DEPTH is a power of two, so pointer arithmetic wraps naturally.
   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush_i) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         rd_d    = rd_q + PTR_W'(pop_n_i);
         wr_d    = push_i ? (wr_q + PTR_W'(1)) : wr_q;
         count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_n_i);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         if (push_i && !flush_i) begin
            mem_q[wr_q] <= data_i;
         end
      end
   end

   assign rd_next = rd_q + PTR_W'(1);
   assign head0_o = mem_q[rd_q];
   assign head1_o = mem_q[rd_next];
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/tinyqv_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tinyqv_instr_fetch
//  Description : Instruction fetch/prefetch stage. Buffers the sequential
//                halfword stream from the QSPI controller and presents one
//                aligned 16- or 32-bit instruction with its PC. Restarts the
//                stream after reset and on every taken branch/jump.
//  Ports       : clk   clock, rising edge
//                rstn  async reset, active low
//                bus   tinyqv_instr_fetch_if.master (memory + core signals)
//  Revision    : 1.0  initial release
// ============================================================================
module tinyqv_instr_fetch
   import tinyqv_instr_fetch_pkg::*;
#(
   parameter int          ADDR_W     = 24,
   parameter int unsigned RESET_ADDR = DEFAULT_RESET_ADDR,
   parameter int          DEPTH_HW   = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   tinyqv_instr_fetch_if.master        bus
);

   localparam int                CNT_W    = $clog2(DEPTH_HW) + 1;
   localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_ADDR) & ~ADDR_W'(1);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   logic [15:0]       head0;
   logic [15:0]       head1;
   logic [CNT_W-1:0]  count;
   logic              head_compressed;
   logic              stall;
   logic              restart;
   logic              retire;
   logic [1:0]        pop_n;
   logic              push;
   logic              mem_stall;
   logic [ADDR_W-1:0] pc_inc;

   // ---------------------------------------------------------------- buffer
   tinyqv_hw_fifo #(
      .DEPTH (DEPTH_HW)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (bus.branch),
      .push_i  (push),
      .data_i  (bus.fetch_data),
      .pop_n_i (pop_n),
      .head0_o (head0),
      .head1_o (head1),
      .count_o (count)
   );

   // ---------------------------------------------------------- stall / pop
   assign head_compressed = is_compressed(head0[1:0]);
   assign stall   = !((count >= CNT_W'(2)) ||
                      ((count == CNT_W'(1)) && head_compressed));
   assign restart = (state_q == ST_RESTART);

   // A branch discards the retirement it arrives with.
   assign retire  = bus.instr_complete && !stall && !bus.branch;
   assign pop_n   = retire ? (head_compressed ? 2'd1 : 2'd2) : 2'd0;
   assign pc_inc  = head_compressed ? ADDR_W'(2) : ADDR_W'(4);

   // One slot of slack is kept unless a pop frees space this same cycle.
   assign mem_stall = (count == CNT_W'(DEPTH_HW)) ||
                      ((count == CNT_W'(DEPTH_HW - 1)) && !retire);

   // Data is only taken from a live stream: not before the first restart,
   // not during the restart cycle (stale), not alongside a branch, and not
   // when the memory ignored fetch_stall.
   assign push = bus.fetch_data_ready && (state_q == ST_RUN) &&
                 !bus.branch && !mem_stall;

   // ------------------------------------------------------------------ FSM
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (bus.branch) begin
         // Also covers a branch during RESTART: newest target wins.
         state_d = ST_RESTART;
         pc_d    = bus.branch_target & ~ADDR_W'(1);
      end else begin
         case (state_q)
            ST_START:   state_d = ST_RESTART;
            ST_RESTART: state_d = ST_RUN;
            ST_RUN: begin
               if (retire) begin
                  pc_d = pc_q + pc_inc;
               end
            end
            default:    state_d = ST_START;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_START;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // -------------------------------------------------------------- outputs
   assign bus.fetch_addr    = pc_q;
   assign bus.fetch_restart = restart;
   assign bus.fetch_stall   = mem_stall;
   assign bus.instr         = {head1, head0};
   assign bus.pc            = pc_q;
   assign bus.is_stall      = stall;

endmodule
`default_nettype wire

// File: tb/tb_tinyqv_instr_fetch.sv
`timescale 1ns/1ps
module tb_tinyqv_instr_fetch;

   logic clk;
   logic rstn;
   int   vec_cnt;
   int   err_cnt;

   tinyqv_instr_fetch_if #(.ADDR_W(24)) bus();

   tinyqv_instr_fetch #(
      .ADDR_W     (24),
      .RESET_ADDR (0),
      .DEPTH_HW   (4)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Advance one clock; return 1ns after the edge so outputs are settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_hw(input logic [15:0] d);
      bus.fetch_data_ready = 1'b1;
      bus.fetch_data       = d;
      step();
      bus.fetch_data_ready = 1'b0;
   endtask

   task automatic retire_one();
      bus.instr_complete = 1'b1;
      step();
      bus.instr_complete = 1'b0;
   endtask

   // Branch, ride through the restart cycle, end in RUN with an empty buffer.
   task automatic do_branch(input logic [23:0] t);
      bus.branch        = 1'b1;
      bus.branch_target = t;
      step();
      bus.branch = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      step();
      step();
      vec_cnt++; if (bus.pc !== 24'h0) begin err_cnt++; $display("FAIL reset_pc: got %h want %h", bus.pc, 24'h0); end
      vec_cnt++; if (bus.is_stall !== 1'b1) begin err_cnt++; $display("FAIL reset_is_stall: got %b want 1", bus.is_stall); end
      vec_cnt++; if (bus.fetch_stall !== 1'b0) begin err_cnt++; $display("FAIL reset_fetch_stall: got %b want 0", bus.fetch_stall); end
      vec_cnt++; if (bus.fetch_restart !== 1'b0) begin err_cnt++; $display("FAIL reset_restart: got %b want 0", bus.fetch_restart); end
      vec_cnt++; if (bus.fetch_addr !== 24'h0) begin err_cnt++; $display("FAIL reset_fetch_addr: got %h want %h", bus.fetch_addr, 24'h0); end
      vec_cnt++; if (bus.instr !== 32'h0) begin err_cnt++; $display("FAIL reset_instr: got %h want %h", bus.instr, 32'h0); end
      rstn = 1'b1;
      step();
      vec_cnt++; if (bus.fetch_restart !== 1'b1) begin err_cnt++; $display("FAIL start_restart: got %b want 1", bus.fetch_restart); end
      vec_cnt++; if (bus.fetch_addr !== 24'h0) begin err_cnt++; $display("FAIL start_fetch_addr: got %h want %h", bus.fetch_addr, 24'h0); end
      step();
      vec_cnt++; if (bus.fetch_restart !== 1'b0) begin err_cnt++; $display("FAIL start_restart_pulse: got %b want 0", bus.fetch_restart); end
   endtask

   task automatic test_addi();
      push_hw(16'h0013);
      vec_cnt++; if (bus.is_stall !== 1'b1) begin err_cnt++; $display("FAIL addi_half_stall: got %b want 1", bus.is_stall); end
      push_hw(16'h0000);
      vec_cnt++; if (bus.is_stall !== 1'b0) begin err_cnt++; $display("FAIL addi_stall: got %b want 0", bus.is_stall); end
      vec_cnt++; if (bus.instr !== 32'h00000013) begin err_cnt++; $display("FAIL addi_instr: got %h want %h", bus.instr, 32'h00000013); end
      vec_cnt++; if (bus.pc !== 24'h0) begin err_cnt++; $display("FAIL addi_pc: got %h want %h", bus.pc, 24'h0); end
      retire_one();
      vec_cnt++; if (bus.pc !== 24'h4) begin err_cnt++; $display("FAIL addi_pc_next: got %h want %h", bus.pc, 24'h4); end
      vec_cnt++; if (bus.is_stall !== 1'b1) begin err_cnt++; $display("FAIL addi_empty_stall: got %b want 1", bus.is_stall); end
   endtask

   task automatic test_compressed();
      do_branch(24'h0);
      push_hw(16'h4501);
      vec_cnt++; if (bus.is_stall !== 1'b0) begin err_cnt++; $display("FAIL c_stall: got %b want 0", bus.is_stall); end
      vec_cnt++; if (bus.instr[15:0] !== 16'h4501) begin err_cnt++; $display("FAIL c_instr: got %h want %h", bus.instr[15:0], 16'h4501); end
      vec_cnt++; if (bus.pc !== 24'h0) begin err_cnt++; $display("FAIL c_pc: got %h want %h", bus.pc, 24'h0); end
      // retire compressed while the low half of the 32-bit instr arrives
      bus.instr_complete   = 1'b1;
      bus.fetch_data_ready = 1'b1;
      bus.fetch_data       = 16'h0593;
      step();
      bus.instr_complete   = 1'b0;
      bus.fetch_data_ready = 1'b0;
      vec_cnt++; if (bus.pc !== 24'h2) begin err_cnt++; $display("FAIL c_pc_next: got %h want %h", bus.pc, 24'h2); end
      vec_cnt++; if (bus.is_stall !== 1'b1) begin err_cnt++; $display("FAIL split_half_stall: got %b want 1", bus.is_stall); end
      // complete while stalled must be ignored
      bus.instr_complete   = 1'b1;
      bus.fetch_data_ready = 1'b1;
      bus.fetch_data       = 16'h00A0;
      step();
      bus.instr_complete   = 1'b0;
      bus.fetch_data_ready = 1'b0;
      vec_cnt++; if (bus.pc !== 24'h2) begin err_cnt++; $display("FAIL split_pc_hold: got %h want %h", bus.pc, 24'h2); end
      vec_cnt++; if (bus.is_stall !== 1'b0) begin err_cnt++; $display("FAIL split_stall: got %b want 0", bus.is_stall); end
      vec_cnt++; if (bus.instr !== 32'h00A00593) begin err_cnt++; $display("FAIL split_instr: got %h want %h", bus.instr, 32'h00A00593); end
      retire_one();
      vec_cnt++; if (bus.pc !== 24'h6) begin err_cnt++; $display("FAIL split_pc_next: got %h want %h", bus.pc, 24'h6); end
   endtask

   task automatic test_full();
      do_branch(24'h000100);
      push_hw(16'h0593);
      push_hw(16'h00A0);
      push_hw(16'h4501);
      vec_cnt++; if (bus.fetch_stall !== 1'b1) begin err_cnt++; $display("FAIL full_fetch_stall: got %b want 1", bus.fetch_stall); end
      // memory ignores fetch_stall: these halfwords must be dropped
      bus.fetch_data_ready = 1'b1;
      bus.fetch_data       = 16'hFFFF;
      step();
      step();
      step();
      bus.fetch_data_ready = 1'b0;
      vec_cnt++; if (bus.instr !== 32'h00A00593) begin err_cnt++; $display("FAIL full_instr: got %h want %h", bus.instr, 32'h00A00593); end
      vec_cnt++; if (bus.pc !== 24'h000100) begin err_cnt++; $display("FAIL full_pc: got %h want %h", bus.pc, 24'h000100); end
      bus.instr_complete = 1'b1;
      #1;
      vec_cnt++; if (bus.fetch_stall !== 1'b0) begin err_cnt++; $display("FAIL full_stall_drop: got %b want 0", bus.fetch_stall); end
      step();
      bus.instr_complete = 1'b0;
      vec_cnt++; if (bus.pc !== 24'h000104) begin err_cnt++; $display("FAIL full_pc_next: got %h want %h", bus.pc, 24'h000104); end
      vec_cnt++; if (bus.instr[15:0] !== 16'h4501) begin err_cnt++; $display("FAIL full_next_instr: got %h want %h", bus.instr[15:0], 16'h4501); end
      retire_one();
      vec_cnt++; if (bus.is_stall !== 1'b1) begin err_cnt++; $display("FAIL full_no_overflow: got %b want 1", bus.is_stall); end
      vec_cnt++; if (bus.pc !== 24'h000106) begin err_cnt++; $display("FAIL full_pc_last: got %h want %h", bus.pc, 24'h000106); end
   endtask

   task automatic test_branch();
      push_hw(16'h0013);
      bus.branch           = 1'b1;
      bus.branch_target    = 24'h001235;
      bus.instr_complete   = 1'b1;
      bus.fetch_data_ready = 1'b1;
      bus.fetch_data       = 16'h1111;
      step();
      bus.branch         = 1'b0;
      bus.instr_complete = 1'b0;
      bus.fetch_data     = 16'h2222;
      vec_cnt++; if (bus.fetch_restart !== 1'b1) begin err_cnt++; $display("FAIL br_restart: got %b want 1", bus.fetch_restart); end
      vec_cnt++; if (bus.pc !== 24'h001234) begin err_cnt++; $display("FAIL br_pc: got %h want %h", bus.pc, 24'h001234); end
      vec_cnt++; if (bus.fetch_addr !== 24'h001234) begin err_cnt++; $display("FAIL br_fetch_addr: got %h want %h", bus.fetch_addr, 24'h001234); end
      vec_cnt++; if (bus.is_stall !== 1'b1) begin err_cnt++; $display("FAIL br_flush: got %b want 1", bus.is_stall); end
      step();
      bus.fetch_data_ready = 1'b0;
      vec_cnt++; if (bus.fetch_restart !== 1'b0) begin err_cnt++; $display("FAIL br_restart_pulse: got %b want 0", bus.fetch_restart); end
      vec_cnt++; if (bus.is_stall !== 1'b1) begin err_cnt++; $display("FAIL br_stale_drop: got %b want 1", bus.is_stall); end
      push_hw(16'h4501);
      vec_cnt++; if (bus.instr[15:0] !== 16'h4501) begin err_cnt++; $display("FAIL br_fresh_instr: got %h want %h", bus.instr[15:0], 16'h4501); end
      // branch again while restart is high: newest target wins
      bus.branch        = 1'b1;
      bus.branch_target = 24'h003000;
      step();
      bus.branch_target = 24'h002000;
      step();
      bus.branch = 1'b0;
      vec_cnt++; if (bus.fetch_restart !== 1'b1) begin err_cnt++; $display("FAIL br2_restart: got %b want 1", bus.fetch_restart); end
      vec_cnt++; if (bus.fetch_addr !== 24'h002000) begin err_cnt++; $display("FAIL br2_addr: got %h want %h", bus.fetch_addr, 24'h002000); end
      step();
      vec_cnt++; if (bus.fetch_restart !== 1'b0) begin err_cnt++; $display("FAIL br2_restart_pulse: got %b want 0", bus.fetch_restart); end
   endtask

   task automatic test_wrap();
      do_branch(24'hFFFFFC);
      push_hw(16'h0013);
      push_hw(16'h0000);
      vec_cnt++; if (bus.pc !== 24'hFFFFFC) begin err_cnt++; $display("FAIL wrap_pc: got %h want %h", bus.pc, 24'hFFFFFC); end
      retire_one();
      vec_cnt++; if (bus.pc !== 24'h000000) begin err_cnt++; $display("FAIL wrap_pc_next: got %h want %h", bus.pc, 24'h000000); end
   endtask

   task automatic test_midreset();
      do_branch(24'h000400);
      push_hw(16'h0013);
      push_hw(16'h0000);
      push_hw(16'h4501);
      vec_cnt++; if (bus.fetch_stall !== 1'b1) begin err_cnt++; $display("FAIL mr_pre_stall: got %b want 1", bus.fetch_stall); end
      rstn = 1'b0;
      #1;
      vec_cnt++; if (bus.pc !== 24'h0) begin err_cnt++; $display("FAIL mr_pc: got %h want %h", bus.pc, 24'h0); end
      vec_cnt++; if (bus.is_stall !== 1'b1) begin err_cnt++; $display("FAIL mr_is_stall: got %b want 1", bus.is_stall); end
      vec_cnt++; if (bus.fetch_stall !== 1'b0) begin err_cnt++; $display("FAIL mr_fetch_stall: got %b want 0", bus.fetch_stall); end
      vec_cnt++; if (bus.instr !== 32'h0) begin err_cnt++; $display("FAIL mr_instr: got %h want %h", bus.instr, 32'h0); end
      vec_cnt++; if (bus.fetch_addr !== 24'h0) begin err_cnt++; $display("FAIL mr_fetch_addr: got %h want %h", bus.fetch_addr, 24'h0); end
      step();
      rstn = 1'b1;
      step();
      vec_cnt++; if (bus.fetch_restart !== 1'b1) begin err_cnt++; $display("FAIL mr_restart: got %b want 1", bus.fetch_restart); end
      vec_cnt++; if (bus.fetch_addr !== 24'h0) begin err_cnt++; $display("FAIL mr_restart_addr: got %h want %h", bus.fetch_addr, 24'h0); end
      step();
      vec_cnt++; if (bus.fetch_restart !== 1'b0) begin err_cnt++; $display("FAIL mr_restart_pulse: got %b want 0", bus.fetch_restart); end
   endtask

   initial begin
      clk                  = 1'b0;
      rstn                 = 1'b0;
      vec_cnt              = 0;
      err_cnt              = 0;
      bus.fetch_data       = 16'h0;
      bus.fetch_data_ready = 1'b0;
      bus.instr_complete   = 1'b0;
      bus.branch           = 1'b0;
      bus.branch_target    = 24'h0;
      #1;
      test_reset();
      test_addi();
      test_compressed();
      test_full();
      test_branch();
      test_wrap();
      test_midreset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
